reg_bus_arbiter: RTL and testbench
==================================

// Module: reg_bus_arbiter
// PURPOSE
//   Shares the single memory-mapped register bus (8-bit address, 32-bit write data, write
//   strobe, registered read data) between two requesters, e.g. the host command handler and
//   the modulator sequencer. Round-robin arbitration, one transaction in flight, every
//   accepted request (read or write) returns exactly one response carrying the read data.
//   Sits between the requesters and the register file; the only master of the bus.
// PARAMETERS
//   RD_LATENCY  1  cycles from bus address valid to bus read data valid (range 1..4)
// PORTS
//   ipClk          in   1       system clock; single clock domain
//   ipReset        in   1       synchronous, active-high reset
//   ipReqValid     in   [1:0]   per-requester request valid; held until accepted
//   opReqReady     out  [1:0]   per-requester accept; transfer on Valid&&Ready at rising ipClk
//   ipReqAddress   in   [1:0][7:0]   request register address
//   ipReqWrData    in   [1:0][31:0]  request write data (ignored for reads)
//   ipReqWrEnable  in   [1:0]   1 = write, 0 = read
//   opRspValid     out  [1:0]   one-cycle response pulse to the owning requester
//   opRspData      out  32      read data of the response (shared, qualified by opRspValid)
//   opAddress      out  8       register bus address
//   opWrData       out  32      register bus write data
//   opWrEnable     out  1       register bus write strobe
//   ipRdData       in   32      register bus read data
//   opBusy         out  1       high while a transaction is in flight (state != IDLE)
// BEHAVIOUR
//   Reset values: opReqReady=0, opRspValid=0, opRspData=0, opAddress=0, opWrData=0,
//     opWrEnable=0, opBusy=0, State=IDLE, LastGrant=1 (requester 0 wins the first tie).
//   States: IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE: Grant = only valid requester; if both valid, the one != LastGrant.
//     opReqReady[Grant] = 1 combinationally, the other 0; no valid -> both 0.
//     On accept: latch address/data/write into bus regs, LastGrant<=Grant, -> ISSUE.
//   ISSUE (1 cycle): opWrEnable = latched write flag; address/data driven. -> WAIT.
//   WAIT (RD_LATENCY cycles, down-counter): opWrEnable=0, opAddress/opWrData held stable.
//     On last WAIT cycle's edge: opRspData<=ipRdData, opRspValid[owner]<=1, -> IDLE.
//   opRspValid is a registered single-cycle pulse, concurrent with the IDLE cycle in which
//     a new request may be accepted (back-to-back throughput: one per RD_LATENCY+2 cycles).
//   Latency: accept edge E0 -> opRspValid high in cycle after edge E(RD_LATENCY+1).
//   Write response returns the register value at ISSUE (pre-write value); no error path.
//   opWrEnable is high for exactly one cycle per accepted write, never for reads.
//   opReqReady is 0 in ISSUE/WAIT and while ipReset is high.
//   Request fields are sampled only at the accept edge; later changes have no effect.
//   Reset mid-transaction: transaction dropped, no opRspValid, opWrEnable low from the
//     next edge; any write already strobed in ISSUE is not undone.
//   LastGrant changes only on accept; a lone requester is granted repeatedly.
// STRUCTURE
//   Package (Structures): typedef REG_REQ {Address[7:0], WrData[31:0], WrEnable};
//     enum ARB_STATE {IDLE, ISSUE, WAIT}.
//   One natural sub-module: rr_arbiter_2 (combinational 2-way round-robin grant + pointer
//     register). Everything else is a single always_ff plus grant/ready combinational logic.
// TESTING (bench instantiates the real register file behind the bus)
//   1. After reset, req0 reads 0x04 -> opRspValid[0] 3 cycles after accept, data
//      0xFFFFF000; opWrEnable never asserted.
//   2. req1 writes 0x02 <- 0x0000005A -> opWrEnable high exactly 1 cycle with opAddress=0x02,
//      opWrData=0x5A; subsequent req1 read of 0x02 returns 0x0000005A.
//   3. Both valid continuously, req0 reads 0x00, req1 reads 0x01 -> accept order
//      0,1,0,1...; each accept 3 cycles apart; responses routed to the correct requester.
//   4. req1 valid while req0's transaction in flight -> req1 accepted exactly once at the
//      next IDLE; no duplicate or lost response.
//   5. ipReset asserted during WAIT of a read -> no opRspValid, all outputs at reset values
//      next cycle; next request after reset completes normally.
//   6. RD_LATENCY=2 with a 2-cycle bus stub -> response 4 cycles after accept with the
//      stub's data; address held stable through both WAIT cycles.

Source files
------------

// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types for the register-bus arbiter.
//   reg_req_t   : one latched bus request (address, write data, write flag)
//   arb_state_t : transaction phase of the single in-flight bus access
//   onehot2     : 1-bit requester index to a 2-bit one-hot select
package reg_bus_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    // Holds RD_LATENCY-1 for RD_LATENCY up to 4.
    localparam int CNT_W  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wr_data;
        logic              wr_enable;
    } reg_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_rr_arbiter_2.sv
// Two-way round-robin grant with a last-grant pointer.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   req        : per-requester request valid
//   enable     : grant may be issued this cycle
//   grant      : one-hot grant (zero when disabled or nothing requested)
//   grant_idx  : index of the requester that would win
// The pointer moves only when a granted request is actually taken, so a
// lone requester keeps winning and a tie goes to the one not served last.
module rr_arbiter_2
    import reg_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic last_grant;

    always_comb begin
        grant_idx = (req == 2'b11) ? ~last_grant : req[1];
        grant     = enable ? (req & onehot2(grant_idx)) : 2'b00;
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (|(req & grant)) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares one register bus between two requesters, one transaction in flight.
// Every accepted read or write returns exactly one response pulse carrying the
// bus read data sampled RD_LATENCY cycles after the address was issued.
// Ports:
//   ipClk, ipReset      : clock, synchronous active-high reset
//   ipReqValid/opReqReady, ipReqAddress/ipReqWrData/ipReqWrEnable : request side
//   opRspValid, opRspData                                        : response side
//   opAddress, opWrData, opWrEnable, ipRdData                    : register bus
//   opBusy              : transaction in flight
module reg_bus_arbiter
    import reg_bus_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                   ipClk,
    input  logic                   ipReset,
    input  logic [1:0]             ipReqValid,
    output logic [1:0]             opReqReady,
    input  logic [1:0][ADDR_W-1:0] ipReqAddress,
    input  logic [1:0][DATA_W-1:0] ipReqWrData,
    input  logic [1:0]             ipReqWrEnable,
    output logic [1:0]             opRspValid,
    output logic [DATA_W-1:0]      opRspData,
    output logic [ADDR_W-1:0]      opAddress,
    output logic [DATA_W-1:0]      opWrData,
    output logic                   opWrEnable,
    input  logic [DATA_W-1:0]      ipRdData,
    output logic                   opBusy
);

    arb_state_t        state;
    arb_state_t        next_state;
    reg_req_t          bus_req;
    reg_req_t          sel_req;
    logic [1:0]        grant;
    logic              grant_idx;
    logic              arb_enable;
    logic              accept;
    logic              owner;
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    // Requests are only offered a grant while idle and out of reset.
    assign arb_enable = (state == IDLE) && !ipReset;

    rr_arbiter_2 u_rr (
        .clk       (ipClk),
        .rst       (ipReset),
        .req       (ipReqValid),
        .enable    (arb_enable),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign opReqReady = grant;
    assign accept     = |(ipReqValid & grant);

    always_comb begin
        sel_req.address   = ipReqAddress[grant_idx];
        sel_req.wr_data   = ipReqWrData[grant_idx];
        sel_req.wr_enable = ipReqWrEnable[grant_idx];
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (wait_cnt == '0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The strobe comes straight from the state so it is high for the single
    // ISSUE cycle only; address and data stay latched until the next accept.
    always_comb begin
        opWrEnable = (state == ISSUE) && bus_req.wr_enable;
        opBusy     = (state != IDLE);
    end

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            bus_req   <= '0;
            owner     <= 1'b0;
            wait_cnt  <= '0;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 2'b00;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus_req <= sel_req;
                        owner   <= grant_idx;
                    end
                end
                ISSUE: begin
                    wait_cnt <= CNT_W'(RD_LATENCY - 1);
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rsp_data  <= ipRdData;
                        rsp_valid <= onehot2(owner);
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign opAddress  = bus_req.address;
    assign opWrData   = bus_req.wr_data;
    assign opRspValid = rsp_valid;
    assign opRspData  = rsp_data;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: two instances (RD_LATENCY 1 and 2), each with a
// register-file stub on its bus, a transaction-level reference model, a
// per-cycle compare process and directed scenarios with literal expectations.
module tb_reg_bus_arbiter;

    typedef struct {
        int          r;
        int          e;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rf_init;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       p_valid[2];
    logic [1:0]       p_we[2];
    logic [1:0][7:0]  p_addr[2];
    logic [1:0][31:0] p_wd[2];
    logic [1:0]       o_ready[2];
    logic [1:0]       o_rsp_valid[2];
    logic [31:0]      o_rsp_data[2];
    logic [7:0]       o_addr[2];
    logic [31:0]      o_wd[2];
    logic             o_we[2];
    logic             o_busy[2];
    logic [31:0]      rd_data[2];

    reg_bus_arbiter #(.RD_LATENCY(1)) dut_l1 (
        .ipClk(clk), .ipReset(rst), .ipReqValid(p_valid[0]), .opReqReady(o_ready[0]),
        .ipReqAddress(p_addr[0]), .ipReqWrData(p_wd[0]), .ipReqWrEnable(p_we[0]),
        .opRspValid(o_rsp_valid[0]), .opRspData(o_rsp_data[0]), .opAddress(o_addr[0]),
        .opWrData(o_wd[0]), .opWrEnable(o_we[0]), .ipRdData(rd_data[0]), .opBusy(o_busy[0])
    );

    reg_bus_arbiter #(.RD_LATENCY(2)) dut_l2 (
        .ipClk(clk), .ipReset(rst), .ipReqValid(p_valid[1]), .opReqReady(o_ready[1]),
        .ipReqAddress(p_addr[1]), .ipReqWrData(p_wd[1]), .ipReqWrEnable(p_we[1]),
        .opRspValid(o_rsp_valid[1]), .opRspData(o_rsp_data[1]), .opAddress(o_addr[1]),
        .opWrData(o_wd[1]), .opWrEnable(o_we[1]), .ipRdData(rd_data[1]), .opBusy(o_busy[1])
    );

    function automatic logic [31:0] dflt(input logic [7:0] a);
        return (a == 8'h04) ? 32'hFFFFF000 : (32'hCAFE0000 | 32'(a));
    endfunction

    // Register file stubs: registered read, data valid 1 (resp. 2) cycles
    // after the address; a write lands on the same edge that samples the read.
    logic [31:0] regs[2][256];
    logic [31:0] rd_pipe[2][2];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rf_init) begin
                for (int i = 0; i < 256; i++) regs[d][i] <= dflt(8'(i));
            end else if (o_we[d]) begin
                regs[d][o_addr[d]] <= o_wd[d];
            end
            rd_pipe[d][0] <= regs[d][o_addr[d]];
            rd_pipe[d][1] <= rd_pipe[d][0];
        end
    end
    assign rd_data[0] = rd_pipe[0][0];
    assign rd_data[1] = rd_pipe[1][1];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A transaction is described by its age in cycles since acceptance:
    // age 1 is the strobe/issue cycle, the response is produced on the edge
    // that ends age RD_LATENCY+1.
    int          lat[2] = '{1, 2};
    bit          started = 1'b0;
    bit          m_act[2];
    int          m_age[2];
    bit          m_own[2];
    bit          m_last[2];
    bit          m_we[2];
    logic [7:0]  m_addr[2];
    logic [31:0] m_wd[2];
    logic [31:0] m_exp[2];
    logic [31:0] m_rdata[2];
    logic [1:0]  m_rsp[2];
    logic [31:0] mmem[2][256];

    ev_t  acc_q[2][$];
    ev_t  rsp_q[2][$];
    int   wr_cnt[2] = '{0, 0};
    logic [7:0]  wr_addr[2];
    logic [31:0] wr_data[2];

    function automatic int pick(input logic [1:0] v, input bit last);
        if (v == 2'b11) return last ? 0 : 1;
        if (v[0]) return 0;
        if (v[1]) return 1;
        return -1;
    endfunction

    task automatic step(input int d);
        int g;
        if (rf_init) for (int i = 0; i < 256; i++) mmem[d][i] = dflt(8'(i));
        if (rst) begin
            m_act[d] = 0; m_age[d] = 0; m_rsp[d] = 2'b00; m_rdata[d] = '0;
            m_addr[d] = '0; m_wd[d] = '0; m_we[d] = 0; m_last[d] = 1;
            started = 1'b1;
        end else begin
            m_rsp[d] = 2'b00;
            if (m_act[d]) begin
                if (m_age[d] == lat[d] + 1) begin
                    m_rsp[d]   = m_own[d] ? 2'b10 : 2'b01;
                    m_rdata[d] = m_exp[d];
                    m_act[d]   = 0;
                end else begin
                    m_age[d]++;
                end
            end else begin
                g = pick(p_valid[d], m_last[d]);
                if (g >= 0) begin
                    m_act[d]  = 1; m_age[d] = 1;
                    m_own[d]  = (g == 1); m_last[d] = (g == 1);
                    m_addr[d] = p_addr[d][g]; m_wd[d] = p_wd[d][g]; m_we[d] = p_we[d][g];
                    m_exp[d]  = mmem[d][m_addr[d]];
                    if (m_we[d]) mmem[d][m_addr[d]] = m_wd[d];
                end
            end
        end
    endtask

    task automatic cmp(input int d);
        int   g;
        logic [1:0] er;
        ev_t  ev;
        g  = pick(p_valid[d], m_last[d]);
        er = (!m_act[d] && !rst && g >= 0) ? ((g == 1) ? 2'b10 : 2'b01) : 2'b00;
        chk($sformatf("d%0d_ready", d),    32'(o_ready[d]), 32'(er));
        chk($sformatf("d%0d_busy", d),     32'(o_busy[d]), 32'(m_act[d]));
        chk($sformatf("d%0d_wr_en", d),    32'(o_we[d]), 32'(m_act[d] && m_age[d] == 1 && m_we[d]));
        chk($sformatf("d%0d_addr", d),     32'(o_addr[d]), 32'(m_addr[d]));
        chk($sformatf("d%0d_wr_data", d),  o_wd[d], m_wd[d]);
        chk($sformatf("d%0d_rsp_valid", d), 32'(o_rsp_valid[d]), 32'(m_rsp[d]));
        chk($sformatf("d%0d_rsp_data", d), o_rsp_data[d], m_rdata[d]);
        for (int r = 0; r < 2; r++) begin
            if (p_valid[d][r] && o_ready[d][r]) begin
                ev.r = r; ev.e = cyc; ev.data = '0;
                acc_q[d].push_back(ev);
            end
            if (o_rsp_valid[d][r]) begin
                ev.r = r; ev.e = cyc - 1; ev.data = o_rsp_data[d];
                rsp_q[d].push_back(ev);
            end
        end
        if (o_we[d]) begin
            wr_cnt[d]++; wr_addr[d] = o_addr[d]; wr_data[d] = o_wd[d];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            step(0);
            step(1);
            @(negedge clk);
            #2;
            if (started) begin
                cmp(0);
                cmp(1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; returns at the falling edge after acceptance
    // with valid dropped.
    task automatic req(input int d, input int r, input bit we, input logic [7:0] a,
                       input logic [31:0] wd);
        bit done = 1'b0;
        p_addr[d][r] = a; p_wd[d][r] = wd; p_we[d][r] = we; p_valid[d][r] = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            if (o_ready[d][r]) begin
                @(posedge clk);
                @(negedge clk);
                p_valid[d][r] = 1'b0;
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            chk($sformatf("d%0d_r%0d_accept_timeout", d, r), 32'd0, 32'd1);
            p_valid[d][r] = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int d, input int n0);
        for (int i = 0; i < 20 && rsp_q[d].size() <= n0; i++) begin
            @(negedge clk);
            #3;
        end
        chk($sformatf("d%0d_rsp_arrived", d), 32'(rsp_q[d].size()), 32'(n0 + 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int  n0, a0, wc, stable;
        ev_t ev;
        rst = 1'b1; rf_init = 1'b1;
        for (int d = 0; d < 2; d++) begin
            p_valid[d] = 2'b11; p_we[d] = 2'b00; p_addr[d] = '0; p_wd[d] = '0;
        end
        repeat (3) @(negedge clk);
        #3;
        chk("reset_ready", 32'(o_ready[0]), 32'd0);
        chk("reset_busy", 32'(o_busy[0]), 32'd0);
        chk("reset_rsp_valid", 32'(o_rsp_valid[0]), 32'd0);
        chk("reset_rsp_data", o_rsp_data[0], 32'd0);
        chk("reset_addr", 32'(o_addr[0]), 32'd0);
        chk("reset_wr_en", 32'(o_we[0]), 32'd0);
        p_valid[0] = 2'b00; p_valid[1] = 2'b00;
        @(negedge clk);
        rst = 1'b0; rf_init = 1'b0;
        @(negedge clk);

        // 1: read of 0x04
        n0 = rsp_q[0].size(); wc = wr_cnt[0];
        req(0, 0, 1'b0, 8'h04, 32'h0);
        wait_rsp(0, n0);
        ev = rsp_q[0][n0];
        chk("t1_owner", 32'(ev.r), 32'd0);
        chk("t1_data", ev.data, 32'hFFFFF000);
        chk("t1_latency", 32'(ev.e - acc_q[0][acc_q[0].size()-1].e), 32'd2);
        chk("t1_no_strobe", 32'(wr_cnt[0] - wc), 32'd0);

        // 2: write 0x02 <- 0x5A, then read it back
        @(negedge clk);
        n0 = rsp_q[0].size(); wc = wr_cnt[0];
        req(0, 1, 1'b1, 8'h02, 32'h0000005A);
        wait_rsp(0, n0);
        chk("t2_strobe_count", 32'(wr_cnt[0] - wc), 32'd1);
        chk("t2_strobe_addr", 32'(wr_addr[0]), 32'h02);
        chk("t2_strobe_data", wr_data[0], 32'h5A);
        chk("t2_wr_rsp_owner", 32'(rsp_q[0][n0].r), 32'd1);
        chk("t2_wr_rsp_prewrite", rsp_q[0][n0].data, 32'hCAFE0002);
        @(negedge clk);
        n0 = rsp_q[0].size();
        req(0, 1, 1'b0, 8'h02, 32'h0);
        wait_rsp(0, n0);
        chk("t2_readback", rsp_q[0][n0].data, 32'h0000005A);

        // 3: both requesters continuously valid
        @(negedge clk);
        n0 = rsp_q[0].size(); a0 = acc_q[0].size();
        fork
            begin for (int k = 0; k < 3; k++) req(0, 0, 1'b0, 8'h00, 32'h0); end
            begin for (int k = 0; k < 3; k++) req(0, 1, 1'b0, 8'h01, 32'h0); end
        join
        repeat (6) @(negedge clk);
        #3;
        chk("t3_accepts", 32'(acc_q[0].size() - a0), 32'd6);
        chk("t3_responses", 32'(rsp_q[0].size() - n0), 32'd6);
        for (int i = 0; i < 6 && a0 + i < acc_q[0].size() && n0 + i < rsp_q[0].size(); i++) begin
            chk($sformatf("t3_order_%0d", i), 32'(acc_q[0][a0+i].r), 32'(i % 2));
            if (i > 0)
                chk($sformatf("t3_spacing_%0d", i),
                    32'(acc_q[0][a0+i].e - acc_q[0][a0+i-1].e), 32'd3);
            chk($sformatf("t3_rsp_route_%0d", i), 32'(rsp_q[0][n0+i].r), 32'(i % 2));
            chk($sformatf("t3_rsp_data_%0d", i), rsp_q[0][n0+i].data,
                (i % 2 == 0) ? 32'hCAFE0000 : 32'hCAFE0001);
        end

        // 4: requester 1 arrives while requester 0 is in flight
        @(negedge clk);
        n0 = rsp_q[0].size(); a0 = acc_q[0].size();
        fork
            req(0, 0, 1'b0, 8'h04, 32'h0);
            begin @(negedge clk); req(0, 1, 1'b0, 8'h03, 32'h0); end
        join
        repeat (8) @(negedge clk);
        #3;
        chk("t4_accepts", 32'(acc_q[0].size() - a0), 32'd2);
        chk("t4_responses", 32'(rsp_q[0].size() - n0), 32'd2);
        if (acc_q[0].size() >= a0 + 2 && rsp_q[0].size() >= n0 + 2) begin
            chk("t4_second_is_r1", 32'(acc_q[0][a0+1].r), 32'd1);
            chk("t4_next_idle", 32'(acc_q[0][a0+1].e - acc_q[0][a0].e), 32'd3);
            chk("t4_rsp0", rsp_q[0][n0].data, 32'hFFFFF000);
            chk("t4_rsp1_route", 32'(rsp_q[0][n0+1].r), 32'd1);
            chk("t4_rsp1", rsp_q[0][n0+1].data, 32'hCAFE0003);
        end

        // 5: reset during the WAIT cycle of a read
        @(negedge clk);
        n0 = rsp_q[0].size();
        req(0, 0, 1'b0, 8'h04, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        p_addr[0][0] = 8'h07; p_we[0][0] = 1'b0; p_valid[0][0] = 1'b1;
        @(negedge clk);
        #3;
        chk("t5_ready_in_reset", 32'(o_ready[0]), 32'd0);
        chk("t5_busy", 32'(o_busy[0]), 32'd0);
        chk("t5_rsp_valid", 32'(o_rsp_valid[0]), 32'd0);
        chk("t5_rsp_data", o_rsp_data[0], 32'd0);
        chk("t5_addr", 32'(o_addr[0]), 32'd0);
        chk("t5_wr_en", 32'(o_we[0]), 32'd0);
        rst = 1'b0;
        req(0, 0, 1'b0, 8'h07, 32'h0);
        wait_rsp(0, n0);
        chk("t5_after_reset", rsp_q[0][n0].data, 32'hCAFE0007);
        repeat (4) @(negedge clk);
        chk("t5_no_dropped_rsp", 32'(rsp_q[0].size() - n0), 32'd1);

        // 6: RD_LATENCY = 2
        @(negedge clk);
        n0 = rsp_q[1].size();
        req(1, 0, 1'b0, 8'h10, 32'h0);
        stable = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            if (o_busy[1] && o_addr[1] == 8'h10) stable++;
            @(negedge clk);
        end
        chk("t6_addr_stable", 32'(stable), 32'd3);
        wait_rsp(1, n0);
        chk("t6_data", rsp_q[1][n0].data, 32'hCAFE0010);
        chk("t6_latency", 32'(rsp_q[1][n0].e - acc_q[1][acc_q[1].size()-1].e), 32'd3);
        @(negedge clk);
        n0 = rsp_q[1].size(); wc = wr_cnt[1];
        req(1, 1, 1'b1, 8'h10, 32'h12345678);
        wait_rsp(1, n0);
        chk("t6_wr_strobe", 32'(wr_cnt[1] - wc), 32'd1);
        @(negedge clk);
        n0 = rsp_q[1].size();
        req(1, 0, 1'b0, 8'h10, 32'h0);
        wait_rsp(1, n0);
        chk("t6_readback", rsp_q[1][n0].data, 32'h12345678);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
